// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the fetch-stage program counter.
//   pc_state_e       : sequencer state (BOOT, RUN, FLUSH, HALT)
//   DEF_RESET_VECTOR : default PC after reset
//   DEF_EXC_VECTOR   : default exception handler entry
//   FLUSH_CNT_W      : width of the post-redirect flush counter
//   misaligned()     : true when a word-fetch target has nonzero low bits
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0040_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;
  localparam int          FLUSH_CNT_W      = 3;

  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control/status bundle between hazard/branch/exception logic
// and the program counter sequencer.
//   master : control side; drives stall/redirect/exception/eret/halt requests,
//            observes the fetch address and qualifiers.
//   slave  : the sequencer itself.
interface pc_sequencer_if #(
  parameter int N_BITS = 32
);
  logic              stall_i;
  logic              redirect_i;
  logic [N_BITS-1:0] redirect_pc_i;
  logic              exc_i;
  logic [N_BITS-1:0] exc_pc_i;
  logic              eret_i;
  logic              halt_i;

  logic [N_BITS-1:0] pc_o;
  logic [N_BITS-1:0] pc_seq_o;
  logic              fetch_valid_o;
  logic              flush_o;
  logic [N_BITS-1:0] epc_o;
  logic              halted_o;
  logic              misalign_o;

  modport master (
    output stall_i, redirect_i, redirect_pc_i, exc_i, exc_pc_i, eret_i, halt_i,
    input  pc_o, pc_seq_o, fetch_valid_o, flush_o, epc_o, halted_o, misalign_o
  );

  modport slave (
    input  stall_i, redirect_i, redirect_pc_i, exc_i, exc_pc_i, eret_i, halt_i,
    output pc_o, pc_seq_o, fetch_valid_o, flush_o, epc_o, halted_o, misalign_o
  );
endinterface

// File: rtl/pc_flush_timer.sv
// pc_flush_timer: loadable down-counter that times the bubble window after a
// redirect, exception or ERET.
//   clk, reset : clock, asynchronous active-low reset
//   load_i     : load load_val_i (takes precedence over counting)
//   load_val_i : window length in cycles
//   done_o     : high in the last cycle of the window (count == 1)
module pc_flush_timer
  import pc_seq_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_i,
  input  logic [FLUSH_CNT_W-1:0] load_val_i,
  output logic                   done_o
);

  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - FLUSH_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == FLUSH_CNT_W'(1));

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with stall hold, branch/jump
// redirect, exception vectoring with EPC capture, ERET, halt and a post-redirect
// flush window.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : pc_sequencer_if.slave
//                inputs  stall_i, redirect_i/redirect_pc_i, exc_i/exc_pc_i,
//                        eret_i, halt_i
//                outputs pc_o, pc_seq_o, fetch_valid_o, flush_o, epc_o,
//                        halted_o, misalign_o
// Optional feature macro: PC_ALIGN_CHK_EN -- redirect/ERET targets with nonzero
// low two bits vector to EXC_VECTOR instead, saving the bad target in EPC and
// pulsing misalign_o. Without it targets load as given and misalign_o is 0.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned       N_BITS       = 32,
  parameter logic [N_BITS-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [N_BITS-1:0] EXC_VECTOR   = DEF_EXC_VECTOR,
  parameter int unsigned       PC_INC       = 4,
  parameter int unsigned       FLUSH_CYCLES = 1
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  pc_state_e         state_q, state_d;
  logic [N_BITS-1:0] pc_q, pc_d;
  logic [N_BITS-1:0] epc_q, epc_d;
  logic [N_BITS-1:0] pc_seq;
  logic [N_BITS-1:0] tgt;
  logic              enter_exc, enter_tgt, bad_tgt;
  logic              tmr_load, tmr_done;

  assign pc_seq = pc_q + N_BITS'(PC_INC);

  // Event decode. Exceptions win everywhere except BOOT; a target load is only
  // legal from RUN (eret beats redirect) or from HALT (redirect only).
  always_comb begin
    tgt       = bus.redirect_pc_i;
    enter_exc = 1'b0;
    enter_tgt = 1'b0;
    if (state_q != BOOT)
      enter_exc = bus.exc_i;
    if (!bus.exc_i) begin
      if (state_q == RUN) begin
        enter_tgt = bus.eret_i | bus.redirect_i;
        if (bus.eret_i) tgt = epc_q;
      end else if (state_q == HALT) begin
        enter_tgt = bus.redirect_i;
      end
    end
  end

`ifdef PC_ALIGN_CHK_EN
  assign bad_tgt = misaligned(tgt[1:0]);
`else
  assign bad_tgt = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
    end
  end

  // Next-state / datapath
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    epc_d    = epc_q;
    tmr_load = 1'b0;
    if (enter_exc || enter_tgt) begin
      // Every redirect-class event opens the bubble window; a zero-length
      // window goes straight back to RUN and fetches the target next cycle.
      tmr_load = 1'b1;
      state_d  = (FLUSH_CYCLES == 0) ? RUN : FLUSH;
      if (enter_exc) begin
        pc_d  = EXC_VECTOR;
        epc_d = bus.exc_pc_i;
      end else if (bad_tgt) begin
        pc_d  = EXC_VECTOR;
        epc_d = tgt;
      end else begin
        pc_d  = tgt;
      end
    end else begin
      unique case (state_q)
        BOOT:  state_d = RUN;
        RUN: begin
          if (bus.halt_i)        state_d = HALT;
          else if (!bus.stall_i) pc_d    = pc_seq;
        end
        FLUSH: if (tmr_done) state_d = RUN;
        HALT:  ;
        default: state_d = BOOT;
      endcase
    end
  end

  pc_flush_timer u_flush_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (FLUSH_CNT_W'(FLUSH_CYCLES)),
    .done_o     (tmr_done)
  );

`ifdef PC_ALIGN_CHK_EN
  logic mis_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mis_q <= 1'b0;
    else        mis_q <= enter_tgt & bad_tgt;
  end
  assign bus.misalign_o = mis_q;
`else
  assign bus.misalign_o = 1'b0;
`endif

  // Outputs
  always_comb begin
    bus.pc_o          = pc_q;
    bus.pc_seq_o      = pc_seq;
    bus.epc_o         = epc_q;
    bus.fetch_valid_o = (state_q == RUN);
    bus.flush_o       = (state_q == FLUSH);
    bus.halted_o      = (state_q == HALT);
  end

endmodule
